// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, fed by a small FIFO.
// Back-to-back frames are sent without an idle bit between them.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Done
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL    = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic fifo_empty;
  logic wr_en;
  logic pop;
  logic bit_end;

  // Pop happens from IDLE, or on the last stop clock so the next start bit follows directly.
  always_comb begin
    fifo_empty = (count == '0);
    o_TX_Ready = (count != FULL);
    wr_en      = i_TX_DV && o_TX_Ready;
    bit_end    = (clk_cnt == CNT_MAX);
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[wr_ptr] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      case (state)
        IDLE: begin
          o_TX_Serial <= 1'b1;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          if (pop) begin
            shift       <= mem[rd_ptr];
            state       <= START;
            o_TX_Active <= 1'b1;
            o_TX_Serial <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            state       <= DATA;
            o_TX_Serial <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx     <= '0;
              state       <= STOP;
              o_TX_Serial <= 1'b1;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_TX_Serial <= shift[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            o_TX_Done <= 1'b1;
            if (pop) begin
              shift       <= mem[rd_ptr];
              state       <= START;
              o_TX_Serial <= 1'b0;
            end else begin
              state       <= IDLE;
              o_TX_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line monitor decodes every frame and checks it against a
// scoreboard of accepted bytes; a second instance at 217 clocks/bit feeds a receiver model.
module tb_uart_tx;

  localparam int CPB    = 4;
  localparam int LB_CPB = 217;
  localparam int FRAME  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       ready, ser, act, done;

  logic       lb_dv = 1'b0;
  logic [7:0] lb_byte = '0;
  logic       lb_ready, lb_ser, lb_act, lb_done;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  logic [7:0] lb_sb[$];
  int frames = 0, b2b = 0, last_start = -1, last_end = -1;
  int done_cnt = 0, lb_done_cnt = 0;
  int done_cyc[$];
  bit mon_busy = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_TX_Ready(ready), .o_TX_Serial(ser), .o_TX_Active(act), .o_TX_Done(done)
  );

  uart_tx #(.CLKS_PER_BIT(LB_CPB), .FIFO_AW(2)) lb_dut (
    .i_Clock(clk), .i_Reset(rst), .i_TX_DV(lb_dv), .i_TX_Byte(lb_byte),
    .o_TX_Ready(lb_ready), .o_TX_Serial(lb_ser), .o_TX_Active(lb_act), .o_TX_Done(lb_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (lb_done === 1'b1) lb_done_cnt++;
  end

  // Called at the first sample point where the line is low; returns at the sample after the frame.
  task automatic mon_frame();
    logic [7:0] exp_b, got;
    logic [9:0] wave;
    bit ok, abort, have;
    int start;
    ok = 1; abort = 0; got = '0;
    start = cyc;
    mon_busy = 1;
    if (start == last_end) b2b++;
    have = (sb.size() > 0);
    exp_b = have ? sb.pop_front() : 8'h00;
    wave = {1'b1, exp_b, 1'b0};
    last_start = start;
    for (int i = 0; i < FRAME; i++) begin
      if (rst) begin
        abort = 1;
        break;
      end
      if (ser !== wave[i / CPB] || act !== 1'b1) ok = 0;
      if (i > 0 && done !== 1'b0) ok = 0;
      if ((i % CPB) == CPB / 2 && i / CPB >= 1 && i / CPB <= 8) got[i / CPB - 1] = ser;
      @(negedge clk);
    end
    if (rst) abort = 1;
    if (!abort) begin
      if (done !== 1'b1) ok = 0;
      if (ser === 1'b1 && act !== 1'b0) ok = 0;
      checks++;
      if (have && ok) passed++;
      else $display("FAIL frame@%0d: decoded %02h, required %02h (queued=%0d, waveform/active/done ok=%0d)",
                    start, got, exp_b, have, ok);
      frames++;
      last_end = cyc;
    end
    mon_busy = 0;
  endtask

  initial forever begin
    @(negedge clk);
    while (!rst && ser === 1'b0) mon_frame();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b, output int c0);
    dv = 1'b1;
    tx_byte = b;
    c0 = cyc;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while ((sb.size() > 0 || mon_busy || act !== 1'b0) && w < budget) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (w < budget) passed++;
    else $display("FAIL idle_timeout: still busy after %0d clocks, required idle", w);
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ser, act, done, ready} !== 4'b1001)
      $display("FAIL reset_values: ser/act/done/ready=%b required 1001", {ser, act, done, ready});
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ser !== 1'b1 || act !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL idle_line: %0d non-idle clocks, required 0", bad);
    else passed++;
  endtask

  task automatic test_single();
    int c0, d0, f0;
    d0 = done_cnt; f0 = frames;
    sb.push_back(8'h55);
    write_byte(8'h55, c0);
    wait_idle(200);
    checks++;
    if (frames != f0 + 1) $display("FAIL single_frames: %0d frames required 1", frames - f0);
    else passed++;
    checks++;
    if (last_start != c0 + 2) $display("FAIL single_latency: start at cycle %0d required %0d", last_start, c0 + 2);
    else passed++;
    checks++;
    if (done_cnt != d0 + 1) $display("FAIL single_done: %0d pulses required 1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int c0, c1, d0, f0, b0;
    d0 = done_cnt; f0 = frames; b0 = b2b;
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    write_byte(8'hA5, c0);
    write_byte(8'h3C, c1);
    wait_idle(300);
    checks++;
    if (frames != f0 + 2 || b2b != b0 + 1)
      $display("FAIL b2b_frames: frames=%0d contiguous=%0d required 2 and 1", frames - f0, b2b - b0);
    else passed++;
    checks++;
    if (last_start != c0 + 2 + FRAME)
      $display("FAIL b2b_second_start: cycle %0d required %0d", last_start, c0 + 2 + FRAME);
    else passed++;
    checks++;
    if (done_cnt != d0 + 2 || done_cyc[$] - done_cyc[$-1] != FRAME)
      $display("FAIL b2b_done: %0d pulses, spacing %0d, required 2 and %0d",
               done_cnt - d0, done_cyc[$] - done_cyc[$-1], FRAME);
    else passed++;
  endtask

  task automatic test_fifo_full();
    logic [5:0] exp_rdy;
    int c, c0, f0, w;
    exp_rdy = 6'b011111;
    f0 = frames; c0 = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ready !== exp_rdy[i]) $display("FAIL full_ready_w%0d: ready=%b required %b", i + 1, ready, exp_rdy[i]);
      else passed++;
      if (i < 5) sb.push_back(8'(i + 1));
      write_byte(8'(i + 1), c);
      if (i == 0) c0 = c;
    end
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cyc != c0 + 2 + FRAME) $display("FAIL full_ready_return: cycle %0d required %0d", cyc, c0 + 2 + FRAME);
    else passed++;
    wait_idle(600);
    repeat (20) @(negedge clk);
    checks++;
    if (frames != f0 + 5) $display("FAIL full_frames: %0d frames required 5", frames - f0);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int c0, c1, d0, f0, bad;
    sb.push_back(8'hFF);
    sb.push_back(8'h42);
    write_byte(8'hFF, c0);
    write_byte(8'h42, c1);
    while (cyc < c0 + 19) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ser, act, done, ready} !== 4'b1001)
      $display("FAIL abort_async: ser/act/done/ready=%b required 1001", {ser, act, done, ready});
    else passed++;
    sb.delete();
    d0 = done_cnt; f0 = frames;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ser !== 1'b1 || act !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || done_cnt != d0 || frames != f0)
      $display("FAIL abort_discard: busy clocks=%0d done=%0d frames=%0d required 0/0/0",
               bad, done_cnt - d0, frames - f0);
    else passed++;
    sb.push_back(8'h81);
    write_byte(8'h81, c0);
    wait_idle(200);
    checks++;
    if (frames != f0 + 1 || done_cnt != d0 + 1)
      $display("FAIL abort_recover: frames=%0d done=%0d required 1/1", frames - f0, done_cnt - d0);
    else passed++;
  endtask

  task automatic lb_receive(output logic [7:0] b, output bit ok);
    int w = 0;
    ok = 1;
    b = '0;
    while (lb_ser !== 1'b0 && w < 20 * LB_CPB) begin
      @(negedge clk);
      w++;
    end
    if (lb_ser !== 1'b0) begin
      ok = 0;
      return;
    end
    repeat (LB_CPB / 2) @(negedge clk);
    if (lb_ser !== 1'b0) ok = 0;
    for (int k = 0; k < 8; k++) begin
      repeat (LB_CPB) @(negedge clk);
      b[k] = lb_ser;
    end
    repeat (LB_CPB) @(negedge clk);
    if (lb_ser !== 1'b1) ok = 0;
  endtask

  task automatic test_loopback();
    logic [7:0] vals [3];
    logic [7:0] got, exp_b;
    bit ok;
    int d0, w;
    vals = '{8'h00, 8'hFF, 8'h5A};
    d0 = lb_done_cnt;
    for (int i = 0; i < 3; i++) begin
      lb_sb.push_back(vals[i]);
      lb_dv = 1'b1;
      lb_byte = vals[i];
      @(negedge clk);
    end
    lb_dv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lb_receive(got, ok);
      exp_b = lb_sb.pop_front();
      checks++;
      if (!ok || got !== exp_b) $display("FAIL loopback_%0d: received %02h (framing ok=%0d) required %02h", i, got, ok, exp_b);
      else passed++;
    end
    w = 0;
    while (lb_act !== 1'b0 && w < 2 * LB_CPB) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (lb_act !== 1'b0 || lb_ready !== 1'b1 || lb_done_cnt != d0 + 3)
      $display("FAIL loopback_end: act=%b ready=%b done=%0d required 0/1/3", lb_act, lb_ready, lb_done_cnt - d0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
